// File: rtl/io_pin_arbiter.sv
// Two-requester arbiter sharing one bidirectional pin: turnaround, timed drive/sample, one-cycle ack.
// Optional IO_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority for simultaneous requests.
module io_pin_arbiter #(
  parameter int HOLD_CYCLES  = 2,
  parameter int SAMPLE_DELAY = 1,
  parameter int TURN_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_wr,
  input  logic [1:0] req_wdata,
  output logic [1:0] ack,
  output logic       rdata,
  output logic       busy,
  output logic       io_en,
  output logic       io_dir,
  output logic       io_dout,
  input  logic       io_din
);

  typedef enum logic [2:0] {IDLE, TURN, WRITE, READ, DONE} state_t;

  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_DELAY - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       id_reg, wr_reg, wdata_reg, last_dir_reg, rdata_reg;
  logic       winner, win_op;

`ifdef IO_ARB_ROUND_ROBIN_EN
  logic ptr_reg;

  always_comb winner = (req == 2'b11) ? ptr_reg : ~req[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_reg <= 1'b0;
    else if (state_reg == IDLE && |req)
      ptr_reg <= ~winner;
  end
`else
  always_comb winner = ~req[0];
`endif

  assign win_op = req_wr[winner];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (|req) begin
          if (win_op != last_dir_reg) begin
            state_next = TURN;
            cnt_next   = TURN_LOAD;
          end else if (win_op) begin
            state_next = WRITE;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = READ;
            cnt_next   = SAMPLE_LOAD;
          end
        end
      end
      TURN: begin
        if (cnt_reg == 4'd0) begin
          state_next = wr_reg ? WRITE : READ;
          cnt_next   = wr_reg ? HOLD_LOAD : SAMPLE_LOAD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WRITE, READ: begin
        if (cnt_reg == 4'd0)
          state_next = DONE;
        else
          cnt_next = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      id_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      wdata_reg    <= 1'b0;
      last_dir_reg <= 1'b0;
      rdata_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && |req) begin
        id_reg    <= winner;
        wr_reg    <= win_op;
        wdata_reg <= req_wdata[winner];
      end
      if (state_next == WRITE && state_reg != WRITE)
        last_dir_reg <= 1'b1;
      else if (state_next == READ && state_reg != READ)
        last_dir_reg <= 1'b0;
      // Pin is captured on the edge that closes the final READ cycle.
      if (state_reg == READ && cnt_reg == 4'd0)
        rdata_reg <= io_din;
    end
  end

  // last_dir already reflects WRITE/READ while in them, so io_dir only needs forcing low in TURN.
  assign busy    = (state_reg != IDLE);
  assign io_en   = busy;
  assign io_dir  = (state_reg != TURN) && last_dir_reg;
  assign io_dout = (state_reg == WRITE) && wdata_reg;
  assign ack     = (state_reg == DONE) ? (id_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_io_pin_arbiter.sv
// Directed plus randomized bench for io_pin_arbiter against a transaction-level timing model.
module tb_io_pin_arbiter;
  localparam int HOLD = 2, SAMP = 1, TURNC = 1;
`ifdef IO_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req_wr, req_wdata, ack;
  logic       rdata, busy, io_en, io_dir, io_dout, io_din;

  int passed = 0;
  int total  = 0;
  bit m_dir, m_ptr, m_rdata;

  always #5 clk = ~clk;

  io_pin_arbiter #(.HOLD_CYCLES(HOLD), .SAMPLE_DELAY(SAMP), .TURN_CYCLES(TURNC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .io_en(io_en), .io_dir(io_dir),
    .io_dout(io_dout), .io_din(io_din)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // One transaction: latch on the next edge, then walk the predicted phase timeline cycle by cycle.
  task automatic txn(input logic [1:0] r, input logic [1:0] wr, input logic [1:0] wd,
                     input logic din, input bit noise);
    int w, t, p, len;
    logic op;
    req = r; req_wr = wr; req_wdata = wd; io_din = din;
    if (r == 2'b11) w = RR ? int'(m_ptr) : 0;
    else            w = r[0] ? 0 : 1;
    op  = wr[w];
    t   = (op != m_dir) ? TURNC : 0;
    p   = op ? HOLD : SAMP;
    len = t + p + 1;
    m_ptr = (w == 0);
    @(posedge clk); #1;
    req_wr = 2'($urandom); req_wdata = 2'($urandom);
    for (int k = 1; k <= len; k++) begin
      req = (noise && k < len) ? 2'($urandom) : 2'b00;
      chk("busy", {1'b0, busy}, 2'd1);
      chk("io_en", {1'b0, io_en}, 2'd1);
      chk("io_dir", {1'b0, io_dir}, {1'b0, (k <= t) ? 1'b0 : op});
      chk("io_dout", {1'b0, io_dout}, {1'b0, (k > t && k < len && op) ? wd[w] : 1'b0});
      if (k == len) begin
        if (!op) m_rdata = din;
        chk("ack", ack, (w == 1) ? 2'b10 : 2'b01);
        chk("rdata", {1'b0, rdata}, {1'b0, m_rdata});
      end else begin
        chk("ack_early", ack, 2'b00);
      end
      @(posedge clk); #1;
    end
    m_dir = op;
    chk("idle_busy", {1'b0, busy}, 2'd0);
    chk("idle_en", {1'b0, io_en}, 2'd0);
    chk("idle_dir", {1'b0, io_dir}, {1'b0, m_dir});
    chk("idle_ack", ack, 2'b00);
    $display("txn req=%b wr=%b wdata=%b din=%b winner=%0d len=%0d ack=%b rdata=%b",
             r, wr, wd, din, w, len, ack, rdata);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; req_wr = 2'b00; req_wdata = 2'b00; io_din = 1'b0;
    m_dir = 1'b0; m_ptr = 1'b0; m_rdata = 1'b0;
    #1;
    chk("rst_busy", {1'b0, busy}, 2'd0);
    chk("rst_ack", ack, 2'b00);
    chk("rst_en", {1'b0, io_en}, 2'd0);
    chk("rst_dir", {1'b0, io_dir}, 2'd0);
    chk("rst_dout", {1'b0, io_dout}, 2'd0);
    chk("rst_rdata", {1'b0, rdata}, 2'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed: turn-then-write, write without turn, read pair, contention.
    txn(2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
    txn(2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
    txn(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    txn(2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) txn(2'b11, 2'b00, 2'b00, 1'(i), 1'b0);

    // Randomized transactions with requests and operand changes while busy.
    for (int i = 0; i < 40; i++)
      txn(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), 1'($urandom), 1'b1);

    // Reset during WRITE.
    req = 2'b01; req_wr = 2'b11; req_wdata = 2'b01;
    @(posedge clk); #1;
    req = 2'b00;
    for (int i = 0; i < 6 && !(busy && io_dir); i++) begin
      @(posedge clk); #1;
    end
    chk("reach_write", {1'b0, busy & io_dir}, 2'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {1'b0, busy}, 2'd0);
    chk("mid_rst_en", {1'b0, io_en}, 2'd0);
    chk("mid_rst_ack", ack, 2'b00);
    chk("mid_rst_dir", {1'b0, io_dir}, 2'd0);
    chk("mid_rst_rdata", {1'b0, rdata}, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_dir = 1'b0; m_ptr = 1'b0; m_rdata = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ack", ack, 2'b00);
      chk("post_rst_busy", {1'b0, busy}, 2'd0);
    end
    txn(2'b01, 2'b11, 2'b01, 1'b0, 1'b0);
    txn(2'b11, 2'b00, 2'b00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
